// File: rtl/fp16_pkg.sv
// Shared fp16 field widths, constants and state/result encodings for the
// fp16 arithmetic datapath.
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;

    localparam logic [EXP_W-1:0] EXP_MAX      = 5'h1F;
    localparam logic [15:0]      POS_ZERO     = 16'h0000;
    localparam logic [15:0]      QNAN_DEFAULT = 16'h7E00;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        CALC,
        NORM,
        DONE
    } state_t;

    // What the DONE stage packs into x.
    typedef enum logic [1:0] {
        RES_NUM,
        RES_ZERO,
        RES_NAN
    } res_kind_t;

    function automatic logic [15:0] inf_pattern(input logic sign);
        return {sign, EXP_MAX, {MAN_W{1'b0}}};
    endfunction

endpackage

// File: rtl/fp16_subtractor_if.sv
// Operand/result handshake bundle for the fp16 subtract unit.
interface fp16_subtractor_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] x;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, x
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, x
    );

endinterface

// File: rtl/ksa.sv
// Kogge-Stone parallel-prefix adder with carry-in.
module ksa #(
    parameter int BITS = 16
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            cin,
    output logic [BITS-1:0] sum,
    output logic            cout
);

    localparam int unsigned N = BITS;

    logic [BITS-1:0] carry;

    // Prefix tree over (generate, propagate); cin is folded into bit 0 generate.
    always_comb begin
        logic [BITS-1:0] gg, pp, gn, pn;
        gg    = a & b;
        pp    = a ^ b;
        gg[0] = gg[0] | (pp[0] & cin);
        for (int unsigned d = 1; d < N; d = d << 1) begin
            gn = gg;
            pn = pp;
            for (int unsigned i = d; i < N; i++) begin
                gn[i] = gg[i] | (pp[i] & gg[i - d]);
                pn[i] = pp[i] & pp[i - d];
            end
            gg = gn;
            pp = pn;
        end
        carry = gg;
    end

    assign sum  = (a ^ b) ^ {carry[BITS-2:0], cin};
    assign cout = carry[BITS-1];

endmodule

// File: rtl/fp16_subtractor.sv
// Sequential fp16 subtractor x = a - b: align, add/subtract, iterative
// one-bit-per-cycle normalisation, then a registered result behind valid/ready.
module fp16_subtractor
    import fp16_pkg::*;
#(
    parameter int          GUARD = 10,
    parameter logic [15:0] QNAN  = QNAN_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    fp16_subtractor_if.slave bus
);

    localparam int         W         = 11 + GUARD;
    localparam logic [5:0] SHIFT_LIM = 6'(W);

    state_t      state;
    res_kind_t   kind;
    logic [15:0] a_q, b_q, x_q;
    logic        out_valid_q;
    logic        sign_q, eff_sub_q;
    logic [5:0]  exp_q;
    logic [W-1:0] big_q, small_q;

    logic         za, zb, sa, sb_eff, a_big, special;
    logic [4:0]   ea, eb, e_big, e_diff;
    logic [9:0]   ma, mb;
    logic [W-1:0] sig_a, sig_b, sig_big, sig_small, sig_small_sh;

    logic [W-1:0] addend, sum;
    logic         cout;
    logic [15:0]  packed_x;

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.x         = x_q;

    // Operand decode for ALIGN: flush exp-0 operands to +0, pick the larger, align the smaller.
    always_comb begin
        ea      = a_q[14:10];
        eb      = b_q[14:10];
        za      = (ea == '0);
        zb      = (eb == '0);
        special = (ea == EXP_MAX) || (eb == EXP_MAX);
        ma      = za ? '0 : a_q[9:0];
        mb      = zb ? '0 : b_q[9:0];
        sa      = za ? 1'b0 : a_q[15];
        sb_eff  = ~(zb ? 1'b0 : b_q[15]);
        sig_a   = za ? '0 : {1'b1, ma, {GUARD{1'b0}}};
        sig_b   = zb ? '0 : {1'b1, mb, {GUARD{1'b0}}};
        a_big   = ({ea, ma} >= {eb, mb});
        if (a_big) begin
            sig_big   = sig_a;
            sig_small = sig_b;
            e_big     = ea;
            e_diff    = ea - eb;
        end else begin
            sig_big   = sig_b;
            sig_small = sig_a;
            e_big     = eb;
            e_diff    = eb - ea;
        end
        sig_small_sh = ({1'b0, e_diff} >= SHIFT_LIM) ? '0 : (sig_small >> e_diff);
    end

    // Effective subtract uses larger + ~smaller + 1; effective add is a plain sum.
    assign addend = eff_sub_q ? ~small_q : small_q;

    ksa #(.BITS(W)) u_ksa (
        .a    (big_q),
        .b    (addend),
        .cin  (eff_sub_q),
        .sum  (sum),
        .cout (cout)
    );

    // Final result encoding from the working registers.
    always_comb begin
        packed_x = POS_ZERO;
        case (kind)
            RES_NAN:  packed_x = QNAN;
            RES_ZERO: packed_x = POS_ZERO;
            default: begin
                if (exp_q >= {1'b0, EXP_MAX}) packed_x = inf_pattern(sign_q);
                else packed_x = {sign_q, exp_q[4:0], big_q[W-2:GUARD]};
            end
        endcase
    end

    // Control FSM and datapath registers; packing takes the first DONE cycle so out_valid trails DONE entry by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            x_q         <= '0;
            out_valid_q <= 1'b0;
            kind        <= RES_NUM;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (special) begin
                        kind  <= RES_NAN;
                        state <= DONE;
                    end else begin
                        kind      <= RES_NUM;
                        big_q     <= sig_big;
                        small_q   <= sig_small_sh;
                        exp_q     <= {1'b0, e_big};
                        sign_q    <= a_big ? sa : sb_eff;
                        eff_sub_q <= (sa != sb_eff);
                        state     <= CALC;
                    end
                end
                CALC: begin
                    if (!eff_sub_q && cout) begin
                        big_q <= {1'b1, sum[W-1:1]};
                        exp_q <= exp_q + 6'd1;
                        state <= DONE;
                    end else if (sum == '0) begin
                        kind  <= RES_ZERO;
                        state <= DONE;
                    end else begin
                        big_q <= sum;
                        state <= sum[W-1] ? DONE : NORM;
                    end
                end
                NORM: begin
                    if (exp_q == 6'd1) begin
                        kind  <= RES_ZERO;
                        state <= DONE;
                    end else begin
                        big_q <= big_q << 1;
                        exp_q <= exp_q - 6'd1;
                        if (big_q[W-2]) state <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        x_q         <= packed_x;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
